// File: rtl/mont_exp.sv
// Left-to-right square-and-multiply modular exponentiation in the Montgomery domain.
// Drives an external Montgomery multiplier through a start/finished handshake.
module mont_exp (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [255:0] i_base,
   input  logic [255:0] i_exp,
   output logic         o_mm_start,
   output logic [255:0] o_mm_a,
   output logic [255:0] o_mm_b,
   input  logic [255:0] i_mm_result,
   input  logic         i_mm_finished,
   output logic [255:0] o_result,
   output logic         o_valid,
   output logic         o_busy
);

   // R mod N for N = 2^255-19, R = 2^256: the Montgomery form of 1.
   localparam logic [255:0] ONE_M = 256'd38;

   typedef enum logic [2:0] {
      IDLE,
      SQ_ISSUE,
      SQ_WAIT,
      MUL_ISSUE,
      MUL_WAIT,
      DONE
   } state_t;

   state_t       state_q, state_d;
   logic [255:0] acc_q, acc_d;
   logic [255:0] base_q, base_d;
   logic [255:0] exp_q, exp_d;
   logic [7:0]   idx_q, idx_d;
   logic [255:0] mm_a_q, mm_a_d;
   logic [255:0] mm_b_q, mm_b_d;
   logic [255:0] result_q, result_d;
   logic         step;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      base_d   = base_q;
      exp_d    = exp_q;
      idx_d    = idx_q;
      mm_a_d   = mm_a_q;
      mm_b_d   = mm_b_q;
      result_d = result_q;
      step     = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               base_d  = i_base;
               exp_d   = i_exp;
               acc_d   = ONE_M;
               idx_d   = 8'd255;
               mm_a_d  = ONE_M;
               mm_b_d  = ONE_M;
               state_d = SQ_ISSUE;
            end
         end
         SQ_ISSUE:  state_d = SQ_WAIT;
         SQ_WAIT: begin
            if (i_mm_finished) begin
               acc_d = i_mm_result;
               if (exp_q[idx_q]) begin
                  mm_a_d  = i_mm_result;
                  mm_b_d  = base_q;
                  state_d = MUL_ISSUE;
               end else begin
                  step = 1'b1;
               end
            end
         end
         MUL_ISSUE: state_d = MUL_WAIT;
         MUL_WAIT: begin
            if (i_mm_finished) begin
               acc_d = i_mm_result;
               step  = 1'b1;
            end
         end
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase

      // Operands for the next square are loaded here so they stay stable until finished.
      if (step) begin
         if (idx_q == 8'd0) begin
            result_d = i_mm_result;
            state_d  = DONE;
         end else begin
            idx_d   = idx_q - 8'd1;
            mm_a_d  = i_mm_result;
            mm_b_d  = i_mm_result;
            state_d = SQ_ISSUE;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         idx_q    <= '0;
         mm_a_q   <= '0;
         mm_b_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         mm_a_q   <= mm_a_d;
         mm_b_q   <= mm_b_d;
         result_q <= result_d;
      end
   end

   always_ff @(posedge i_clk) begin
      base_q <= base_d;
      exp_q  <= exp_d;
   end

   assign o_mm_start = (state_q == SQ_ISSUE) || (state_q == MUL_ISSUE);
   assign o_mm_a     = mm_a_q;
   assign o_mm_b     = mm_b_q;
   assign o_result   = result_q;
   assign o_valid    = (state_q == DONE);
   assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mont_exp.sv
// Scoreboard bench for mont_exp with a behavioural Montgomery multiplier of configurable latency.
module tb_mont_exp;

   localparam logic [255:0] N = (256'd1 << 255) - 256'd19;

   logic         i_clk;
   logic         i_rst_n;
   logic         i_start;
   logic [255:0] i_base;
   logic [255:0] i_exp;
   logic         o_mm_start;
   logic [255:0] o_mm_a;
   logic [255:0] o_mm_b;
   logic [255:0] i_mm_result;
   logic         i_mm_finished;
   logic [255:0] o_result;
   logic         o_valid;
   logic         o_busy;

   mont_exp dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_base        (i_base),
      .i_exp         (i_exp),
      .o_mm_start    (o_mm_start),
      .o_mm_a        (o_mm_a),
      .o_mm_b        (o_mm_b),
      .i_mm_result   (i_mm_result),
      .i_mm_finished (i_mm_finished),
      .o_result      (o_result),
      .o_valid       (o_valid),
      .o_busy        (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [255:0] res;
      int           pulses;
   } exp_t;

   typedef struct {
      logic [255:0] a;
      logic [255:0] b;
   } ops_t;

   exp_t q[$];
   ops_t opq[$];
   int   checks = 0;
   int   errors = 0;
   int   lat = 1;
   int   pulses = 0;

   function automatic logic [255:0] mm(input logic [255:0] x, input logic [255:0] y);
      logic [513:0] t;
      t = {258'd0, x} * {258'd0, y};
      for (int i = 0; i < 256; i++) begin
         if (t[0]) t = t + {258'd0, N};
         t = t >> 1;
      end
      if (t >= {258'd0, N}) t = t - {258'd0, N};
      return t[255:0];
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   // Behavioural multiplier: responds lat cycles after each start pulse.
   initial begin : responder
      logic [255:0] ca, cb;
      int cnt;
      bit pend;
      ops_t e;
      pend = 0;
      cnt = 0;
      ca = '0;
      cb = '0;
      i_mm_finished = 1'b0;
      i_mm_result = '0;
      forever begin
         @(negedge i_clk);
         i_mm_finished = 1'b0;
         if (!i_rst_n) begin
            pend = 0;
         end else if (pend) begin
            chk("mm_a_stable", o_mm_a, ca);
            chk("mm_b_stable", o_mm_b, cb);
            chk("mm_start_low_wait", {255'd0, o_mm_start}, 256'd0);
            cnt--;
            if (cnt == 0) begin
               i_mm_result = mm(ca, cb);
               i_mm_finished = 1'b1;
               pend = 0;
            end
         end else if (o_mm_start) begin
            ca = o_mm_a;
            cb = o_mm_b;
            pend = 1;
            cnt = lat;
            if (opq.size() > 0) begin
               e = opq.pop_front();
               chk("op_order_a", ca, e.a);
               chk("op_order_b", cb, e.b);
            end
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            pulses = 0;
         end else begin
            if (o_mm_start) pulses++;
            if (o_valid) begin
               if (q.size() == 0) begin
                  chk("unexpected_valid", {255'd0, o_valid}, 256'd0);
               end else begin
                  e = q.pop_front();
                  chk("result", o_result, e.res);
                  chk("start_pulses", 256'(pulses), 256'(e.pulses));
                  chk("busy_in_done", {255'd0, o_busy}, 256'd1);
               end
               pulses = 0;
            end
         end
      end
   end

   task automatic run(input logic [255:0] b, input logic [255:0] e, input logic [255:0] res,
                      input int np, input int l, input bit poke, input bit rel);
      exp_t x;
      bit busy_ok, seen;
      lat = l;
      for (int t = 0; t < 100 && o_busy; t++) @(negedge i_clk);
      @(negedge i_clk);
      if (rel) i_rst_n = 1'b1;
      i_start = 1'b1;
      i_base = b;
      i_exp = e;
      x.res = res;
      x.pulses = np;
      q.push_back(x);
      @(negedge i_clk);
      i_start = 1'b0;
      busy_ok = 1;
      seen = 0;
      for (int t = 0; t < 20000; t++) begin
         if (o_valid) begin
            seen = 1;
            break;
         end
         if (!o_busy) busy_ok = 0;
         if (poke && t == 3) begin
            i_start = 1'b1;
            i_base = 256'h999;
            i_exp = 256'd7;
         end
         if (poke && t == 4) i_start = 1'b0;
         @(negedge i_clk);
      end
      chk("valid_seen", {255'd0, seen}, 256'd1);
      chk("busy_throughout", {255'd0, busy_ok}, 256'd1);
      if (poke) begin
         i_start = 1'b1;
         i_base = 256'h777;
         i_exp = 256'd9;
         @(negedge i_clk);
         i_start = 1'b0;
         chk("start_ignored_in_done", {255'd0, o_busy}, 256'd0);
      end else begin
         @(negedge i_clk);
      end
      @(negedge i_clk);
      chk("idle_after_done", {255'd0, o_busy}, 256'd0);
      chk("result_held", o_result, res);
   endtask

   task automatic load_ops(input int nsq, input logic [255:0] tail_a[5], input logic [255:0] tail_b[5], input int ntail);
      ops_t o;
      for (int i = 0; i < nsq; i++) begin
         o.a = 256'd38;
         o.b = 256'd38;
         opq.push_back(o);
      end
      for (int i = 0; i < ntail; i++) begin
         o.a = tail_a[i];
         o.b = tail_b[i];
         opq.push_back(o);
      end
   endtask

   initial begin : stim
      logic [255:0] ta[5];
      logic [255:0] tb[5];
      i_rst_n = 1'b0;
      i_start = 1'b0;
      i_base = '0;
      i_exp = '0;
      repeat (3) @(negedge i_clk);
      chk("rst_result", o_result, 256'd0);
      chk("rst_valid", {255'd0, o_valid}, 256'd0);
      chk("rst_busy", {255'd0, o_busy}, 256'd0);
      chk("rst_mm_start", {255'd0, o_mm_start}, 256'd0);
      chk("rst_mm_a", o_mm_a, 256'd0);
      chk("rst_mm_b", o_mm_b, 256'd0);

      // Start accepted in the very first cycle after reset release.
      run(256'hABCDEF, 256'd0, 256'd38, 256, 1, 0, 1);
      run(256'h1234, 256'd1, 256'h1234, 257, 2, 0, 0);
      run(256'd38, {256{1'b1}}, 256'd38, 512, 1, 0, 0);

      // 76 is Montgomery form of 2, so 2^5 = 32 maps to 32*38 = 1216.
      ta[0] = 256'd38;  tb[0] = 256'd38;
      ta[1] = 256'd38;  tb[1] = 256'd76;
      ta[2] = 256'd76;  tb[2] = 256'd76;
      ta[3] = 256'd152; tb[3] = 256'd152;
      ta[4] = 256'd608; tb[4] = 256'd76;
      load_ops(253, ta, tb, 5);
      run(256'd76, 256'd5, 256'd1216, 258, 3, 0, 0);
      chk("op_queue_drained", 256'(opq.size()), 256'd0);

      run(256'd76, 256'd3, 256'd304, 258, 1, 1, 0);

      // Reset while the final multiply is outstanding.
      lat = 6;
      @(negedge i_clk);
      i_start = 1'b1;
      i_base = 256'h1234;
      i_exp = 256'd1;
      @(negedge i_clk);
      i_start = 1'b0;
      begin
         bit hit;
         hit = 0;
         for (int t = 0; t < 3000; t++) begin
            if (o_mm_start && o_mm_b == 256'h1234) begin
               hit = 1;
               break;
            end
            @(negedge i_clk);
         end
         chk("reached_mul_issue", {255'd0, hit}, 256'd1);
      end
      @(negedge i_clk);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      chk("mid_rst_result", o_result, 256'd0);
      chk("mid_rst_valid", {255'd0, o_valid}, 256'd0);
      chk("mid_rst_busy", {255'd0, o_busy}, 256'd0);
      chk("mid_rst_mm_start", {255'd0, o_mm_start}, 256'd0);
      chk("mid_rst_mm_a", o_mm_a, 256'd0);
      chk("mid_rst_mm_b", o_mm_b, 256'd0);
      run(256'h1234, 256'd1, 256'h1234, 257, 2, 0, 1);

      chk("scoreboard_empty", 256'(q.size()), 256'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
